// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: SLICE bits per clock, carry held in a register between slices.
// Optional ADDSUB_SATURATE_EN clamps the sum to the signed limit when overflow occurs.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             carryin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0 || WIDTH < 2) begin : g_bad_params
      $error("addsub_seq: WIDTH must be a multiple of SLICE and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] xr, yr;
  logic             c;
  logic [IW-1:0]    idx;
  logic [SLICE:0]   slice_sum;
  logic             last;
  logic             accept;
  logic             ovf_final;

  always_comb begin
    slice_sum = {1'b0, xr[int'(idx)*SLICE +: SLICE]}
              + {1'b0, yr[int'(idx)*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, c};
    last      = (idx == LAST);
    accept    = start && (state != RUN);
    // Only meaningful on the last slice, where slice_sum[SLICE-1] is the result MSB.
    ovf_final = (xr[WIDTH-1] == yr[WIDTH-1]) && (slice_sum[SLICE-1] != xr[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr       <= '0;
      yr       <= '0;
      c        <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      xr  <= x;
      yr  <= sub ? ~y : y;
      c   <= sub | carryin;
      idx <= '0;
    end else if (state == RUN) begin
      sum[int'(idx)*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
      c   <= slice_sum[SLICE];
      idx <= idx + 1'b1;
      if (last) begin
        carryout <= slice_sum[SLICE];
        overflow <= ovf_final;
`ifdef ADDSUB_SATURATE_EN
        if (ovf_final)
          sum <= xr[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

endmodule
